// File: rtl/sbox_stage_seq.sv
// sbox_stage_seq: multi-cycle DES substitution (S1..S8), LANES boxes evaluated per clock.
// Valid/ready on both sides; the result is held in out_32 until the consumer takes it.
module sbox_stage_seq #(
    parameter int unsigned LANES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_48,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_32,
    output logic        busy
);
    localparam int unsigned STEPS = 8 / LANES;
    localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("sbox_stage_seq: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // DES S-box tables; each entry is a nibble, entry (row*16+col) sits at the MSB end first.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] step;
    logic [47:0]   in_reg;
    logic [5:0]    grp [8];
    logic [3:0]    work [8];
    logic [3:0]    work_nxt [8];
    logic [31:0]   work_flat;
    logic          accept;
    logic          last;

    // Box n takes group n (S1 at the MSB end) and drives nibble n of the result.
    for (genvar i = 0; i < 8; i++) begin : g_slice
        assign grp[i] = in_reg[47-6*i -: 6];
        assign work_flat[31-4*i -: 4] = work_nxt[i];
    end

    assign accept = in_valid & in_ready & ~clear;
    assign last   = (step == LAST_STEP);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = BUSY;
                BUSY:    if (last) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake and status outputs, decoded from state only.
    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        busy      = (state == BUSY);
    end

    // Boxes step*LANES .. step*LANES+LANES-1 overwrite their nibbles of the working copy.
    always_comb begin
        logic [2:0]   bidx;
        logic [5:0]   g;
        logic [255:0] row;
        work_nxt = work;
        bidx = '0;
        g    = '0;
        row  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            bidx = 3'(32'(step) * LANES + l);
            g    = grp[bidx];
            row  = SBOX[bidx] << {g[5], g[0], g[4:1], 2'b00};
            work_nxt[bidx] = row[255:252];
        end
    end

    // Datapath: capture on accept, substitute during BUSY, publish on the last step.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_reg <= '0;
            step   <= '0;
            work   <= '{default: '0};
            out_32 <= '0;
        end else if (accept) begin
            in_reg <= in_48;
            step   <= '0;
        end else if (state == BUSY && !clear) begin
            work <= work_nxt;
            if (last) out_32 <= work_flat;
            else      step   <= step + 1'b1;
        end
    end
endmodule

// File: tb/tb_sbox_stage_seq.sv
// Scoreboard bench for sbox_stage_seq: one instance per LANES value (1, 2, 4, 8).
// Drivers push expected results; a monitor checks value, latency, hold and BUSY status.
module tb_sbox_stage_seq;
    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        clear [ND];
    logic        iv    [ND];
    logic        ir    [ND];
    logic [47:0] din   [ND];
    logic        ov    [ND];
    logic        ordy  [ND];
    logic [31:0] dout  [ND];
    logic        busy  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sbox_stage_seq #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .n_rst    (n_rst),
            .clear    (clear[g]),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_48    (din[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_32   (dout[g]),
            .busy     (busy[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        int unsigned acc;
    } exp_t;

    exp_t        sb [ND][$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic        rand_on = 1'b0;
    logic        ov_seen [ND] = '{default: 1'b0};
    logic [31:0] held    [ND] = '{default: '0};

    localparam logic [47:0] VEC = 48'h6117BA866527;

    // FIPS 46-3 S-box tables, row-major, decimal.
    int unsigned SB_TBL [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] model(input logic [47:0] x);
        logic [31:0] r;
        logic [47:0] t;
        logic [5:0]  g;
        int unsigned idx;
        r = '0;
        t = x;
        for (int b = 0; b < 8; b++) begin
            g   = t[47:42];
            t   = t << 6;
            idx = {g[5], g[0]} * 16 + g[4:1];
            r   = {r[27:0], 4'(SB_TBL[b][idx])};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Random backpressure on the LANES=2 instance during the regression.
    always begin
        @(posedge clk);
        #2;
        if (rand_on) ordy[1] = 1'($urandom_range(0, 1));
    end

    // Monitor: samples just before each rising edge, after all drivers have settled.
    always begin
        @(negedge clk);
        #4;
        for (int d = 0; d < ND; d++) begin
            if (!n_rst) begin
                ov_seen[d] = 1'b0;
            end else if (ov[d]) begin
                if (!ov_seen[d]) begin
                    ov_seen[d] = 1'b1;
                    held[d]    = dout[d];
                    if (sb[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result lanes=%0d: got %h, required no result", 1 << d, dout[d]);
                    end else begin
                        chk($sformatf("result lanes=%0d", 1 << d), 48'(dout[d]), 48'(sb[d][0].data));
                        chk($sformatf("latency lanes=%0d", 1 << d), 48'(cyc - sb[d][0].acc), 48'(8 >> d));
                    end
                end else begin
                    chk($sformatf("hold lanes=%0d", 1 << d), 48'(dout[d]), 48'(held[d]));
                end
                if (ordy[d]) begin
                    if (sb[d].size() > 0) void'(sb[d].pop_front());
                    ov_seen[d] = 1'b0;
                end
            end else begin
                ov_seen[d] = 1'b0;
                if (sb[d].size() > 0 && cyc >= sb[d][0].acc) begin
                    chk($sformatf("busy_window lanes=%0d", 1 << d), 48'(busy[d]), 48'd1);
                    chk($sformatf("busy_in_ready lanes=%0d", 1 << d), 48'(ir[d]), 48'd0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input int d, input logic [47:0] v, input logic [31:0] e);
        int n;
        n     = 0;
        din[d] = v;
        iv[d]  = 1'b1;
        #1;
        while (!(ir[d] && !clear[d])) begin
            tick();
            #1;
            n++;
            if (n > 200) begin
                chk($sformatf("accept_timeout lanes=%0d", 1 << d), 48'(ir[d]), 48'd1);
                iv[d] = 1'b0;
                return;
            end
        end
        sb[d].push_back('{e, cyc + 1});
        tick();
        iv[d] = 1'b0;
    endtask

    task automatic wait_ov(input int d);
        int n;
        n = 0;
        while (!ov[d]) begin
            tick();
            n++;
            if (n > 50) begin
                chk($sformatf("out_valid_timeout lanes=%0d", 1 << d), 48'(ov[d]), 48'd1);
                return;
            end
        end
    endtask

    task automatic drain();
        int n;
        int pend;
        n = 0;
        do begin
            tick();
            pend = 0;
            for (int d = 0; d < ND; d++) pend += sb[d].size();
            n++;
        end while (pend != 0 && n < 500);
        chk("drain_pending", 48'(pend), 48'd0);
        tick();
    endtask

    initial begin
        logic [63:0] r;
        logic [47:0] v;
        n_rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            clear[d] = 1'b0;
            iv[d]    = 1'b0;
            din[d]   = '0;
            ordy[d]  = 1'b1;
        end
        #1 n_rst = 1'b0;
        #10;
        for (int d = 0; d < ND; d++) begin
            chk("reset_out_valid", 48'(ov[d]), 48'd0);
            chk("reset_in_ready", 48'(ir[d]), 48'd1);
            chk("reset_busy", 48'(busy[d]), 48'd0);
            chk("reset_out_32", 48'(dout[d]), 48'd0);
        end
        tick();
        n_rst = 1'b1;
        tick();

        // Zero input, LANES=2: row 0 / col 0 of every box.
        send(1, 48'h0, 32'hEFA72C4D);
        drain();

        // DES round-1 vector on every LANES value.
        for (int d = 0; d < ND; d++) send(d, VEC, 32'h5C82B597);
        drain();

        // S1 group 011011 -> row 1, col 13 -> 5; other boxes see zero.
        send(0, {6'b011011, 42'h0}, 32'h5FA72C4D);
        drain();

        // Backpressure on LANES=2 with a second input pending.
        ordy[1] = 1'b0;
        send(1, 48'h0, 32'hEFA72C4D);
        wait_ov(1);
        din[1] = VEC;
        iv[1]  = 1'b1;
        repeat (10) begin
            #1 chk("bp_in_ready", 48'(ir[1]), 48'd0);
            tick();
        end
        ordy[1] = 1'b1;
        #1 chk("bp_accept_same_cycle", 48'(ir[1]), 48'd1);
        send(1, VEC, 32'h5C82B597);
        drain();

        // clear at step 1 of a LANES=1 run discards the result.
        send(0, VEC, 32'h5C82B597);
        tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        sb[0].delete();
        #1;
        chk("clear_idle_in_ready", 48'(ir[0]), 48'd1);
        chk("clear_idle_busy", 48'(busy[0]), 48'd0);
        repeat (10) begin
            tick();
            chk("clear_no_valid", 48'(ov[0]), 48'd0);
        end

        // clear together with in_valid accepts nothing.
        din[0]   = VEC;
        iv[0]    = 1'b1;
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        iv[0]    = 1'b0;
        #1 chk("clear_with_valid_busy", 48'(busy[0]), 48'd0);
        repeat (10) begin
            tick();
            chk("clear_with_valid_no_valid", 48'(ov[0]), 48'd0);
        end

        // Asynchronous reset while LANES=4 sits in DONE.
        ordy[2] = 1'b0;
        send(2, VEC, 32'h5C82B597);
        wait_ov(2);
        tick();
        #1 n_rst = 1'b0;
        for (int d = 0; d < ND; d++) sb[d].delete();
        #1;
        chk("async_rst_out_valid", 48'(ov[2]), 48'd0);
        chk("async_rst_out_32", 48'(dout[2]), 48'd0);
        chk("async_rst_busy", 48'(busy[2]), 48'd0);
        chk("async_rst_in_ready", 48'(ir[2]), 48'd1);
        ordy[2] = 1'b1;
        tick();
        n_rst = 1'b1;
        tick();

        // Random regression on LANES=2 with input gaps and output stalls.
        rand_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom(), $urandom()};
            v = r[47:0];
            repeat ($urandom_range(0, 2)) tick();
            send(1, v, model(v));
        end
        drain();
        rand_on = 1'b0;
        ordy[1] = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
